// File: rtl/au_cmp6_uns_ser_pkg.sv
// Shared types and sizing helpers for the digit-serial unsigned comparator.
package au_cmp6_uns_ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic le;
    logic ge;
    logic ne;
  } flags_t;

  localparam flags_t FLAGS_RST = 6'b000000;
  localparam flags_t FLAGS_EQ  = 6'b001110;

  function automatic int calc_ndig(input int width, input int digit);
    return (width + digit - 1) / digit;
  endfunction

  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/au_cmp6_uns_ser_if.sv
// Operand/result handshake bundle for the digit-serial comparator.
interface au_cmp6_uns_ser_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             gt;
  logic             eq;
  logic             le;
  logic             ge;
  logic             ne;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, lt, gt, eq, le, ge, ne, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, lt, gt, eq, le, ge, ne, busy
  );
endinterface

// File: rtl/au_cmp6_uns.sv
// Combinational six-output unsigned comparator; ARCH picks the lt/eq structure.
module au_cmp6_uns #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             le,
  output logic             ge,
  output logic             ne
);
  logic w_lt;
  logic w_eq;

  generate
    if (ARCH == 1) begin : g_ripple
      // LSB-up scan: a higher differing bit overrides any lower decision.
      always_comb begin
        w_lt = 1'b0;
        w_eq = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
          if (a[i] != b[i]) begin
            w_lt = b[i];
            w_eq = 1'b0;
          end
        end
      end
    end else if (ARCH == 2) begin : g_sub
      logic [WIDTH:0] w_diff;
      assign w_diff = {1'b0, a} - {1'b0, b};
      assign w_lt   = w_diff[WIDTH];
      assign w_eq   = (w_diff[WIDTH-1:0] == '0);
    end else begin : g_rel
      assign w_lt = (a < b);
      assign w_eq = (a == b);
    end
  endgenerate

  assign lt = w_lt;
  assign eq = w_eq;
  assign gt = ~w_lt & ~w_eq;
  assign le = w_lt | w_eq;
  assign ge = ~w_lt;
  assign ne = ~w_eq;
endmodule

// File: rtl/au_cmp6_uns_ser.sv
// Digit-serial unsigned comparator: scans MSB digit first, stops at first difference.
module au_cmp6_uns_ser
  import au_cmp6_uns_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1,
  parameter int ARCH  = 0
) (
  input logic               clk,
  input logic               rst_n,
  au_cmp6_uns_ser_if.slave  bus
);
  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int EXT_W = NDIG * DIGIT;
  localparam int CNT_W = calc_cnt_w(NDIG);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [EXT_W-1:0]   r_a;
  logic [EXT_W-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  flags_t             r_flags;
  flags_t             w_slice;
  logic               w_load;
  logic               w_shift;
  logic               w_done_diff;
  logic               w_done_eq;
  logic               w_sl_lt, w_sl_gt, w_sl_eq, w_sl_le, w_sl_ge, w_sl_ne;

  au_cmp6_uns #(
    .WIDTH (DIGIT),
    .ARCH  (ARCH)
  ) u_digit (
    .a  (r_a[EXT_W-1 -: DIGIT]),
    .b  (r_b[EXT_W-1 -: DIGIT]),
    .lt (w_sl_lt),
    .gt (w_sl_gt),
    .eq (w_sl_eq),
    .le (w_sl_le),
    .ge (w_sl_ge),
    .ne (w_sl_ne)
  );

  assign w_slice = '{lt: w_sl_lt, gt: w_sl_gt, eq: w_sl_eq,
                     le: w_sl_le, ge: w_sl_ge, ne: w_sl_ne};

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_done_diff = 1'b0;
    w_done_eq   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_sl_eq) begin
          w_done_diff = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == '0) begin
          w_done_eq   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_shift     = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_flags <= FLAGS_RST;
    end else begin
      r_state <= w_state_nxt;
      if (w_load)       r_cnt <= CNT_W'(NDIG - 1);
      else if (w_shift) r_cnt <= r_cnt - CNT_W'(1);
      // Flags persist after DONE until the next result overwrites them.
      if (w_done_diff)    r_flags <= w_slice;
      else if (w_done_eq) r_flags <= FLAGS_EQ;
    end
  end

  // Operand shift registers: pure data, zero-extended at the MSB on capture.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_a <= EXT_W'(bus.a);
      r_b <= EXT_W'(bus.b);
    end else if (w_shift) begin
      r_a <= r_a << DIGIT;
      r_b <= r_b << DIGIT;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.lt        = r_flags.lt;
  assign bus.gt        = r_flags.gt;
  assign bus.eq        = r_flags.eq;
  assign bus.le        = r_flags.le;
  assign bus.ge        = r_flags.ge;
  assign bus.ne        = r_flags.ne;
endmodule

// File: tb/tb_au_cmp6_uns_ser.sv
// Bench for au_cmp6_uns_ser across several WIDTH/DIGIT/ARCH configurations.
module tb_au_cmp6_uns_ser;
  localparam int NDUT = 10;
  localparam logic [5:0] F_GT = 6'b010011;
  localparam logic [5:0] F_LT = 6'b100101;
  localparam logic [5:0] F_EQ = 6'b001110;

  function automatic int cfg_w(input int i);
    case (i)
      0: return 8;   1: return 8;   2: return 16;  3: return 1;
      4: return 7;   5: return 7;   6: return 7;   7: return 32;
      8: return 32;  default: return 32;
    endcase
  endfunction

  function automatic int cfg_d(input int i);
    case (i)
      0: return 1;   1: return 3;   2: return 1;   3: return 1;
      4: return 1;   5: return 4;   6: return 7;   7: return 1;
      8: return 4;   default: return 32;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid_drv;
  logic        out_ready_drv;
  logic [31:0] a_drv, b_drv;
  int          sel;

  logic [NDUT-1:0]      ov_v, ir_v, busy_v;
  logic [NDUT-1:0][5:0] fl_v;

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int W = cfg_w(g);
      localparam int D = cfg_d(g);
      au_cmp6_uns_ser_if #(.WIDTH(W)) bus ();
      assign bus.in_valid  = in_valid_drv && (sel == g);
      assign bus.a         = a_drv[W-1:0];
      assign bus.b         = b_drv[W-1:0];
      assign bus.out_ready = out_ready_drv;
      au_cmp6_uns_ser #(.WIDTH(W), .DIGIT(D), .ARCH(g % 3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
      );
      assign ov_v[g]   = bus.out_valid;
      assign ir_v[g]   = bus.in_ready;
      assign busy_v[g] = bus.busy;
      assign fl_v[g]   = {bus.lt, bus.gt, bus.eq, bus.le, bus.ge, bus.ne};
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic [5:0] ref_flags(input int w, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] am, bm;
    am = a & wmask(w);
    bm = b & wmask(w);
    return {am < bm, am > bm, am == bm, am <= bm, am >= bm, am != bm};
  endfunction

  // Latency from the highest differing bit's position in the zero-padded word.
  function automatic int ref_k(input int w, input int d, input logic [31:0] a, input logic [31:0] b);
    int nd, e, p;
    logic [31:0] x;
    nd = (w + d - 1) / d;
    e  = nd * d;
    x  = (a ^ b) & wmask(w);
    if (x == 0) return nd;
    p = 0;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    return (e - 1 - p) / d + 1;
  endfunction

  task automatic run_cmp(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input int exp_k, input logic [5:0] exp_fl, input string nm);
    int cyc;
    cyc = 0;
    while (!ir_v[idx] && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk({nm, " in_ready"}, 32'(ir_v[idx]), 32'd1);
    sel = idx; a_drv = a; b_drv = b; in_valid_drv = 1'b1;
    @(posedge clk); #1;
    in_valid_drv = 1'b0;
    a_drv = ~a; b_drv = a;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (ov_v[idx]) break;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(exp_k));
    chk({nm, " flags"}, 32'(fl_v[idx]), 32'(exp_fl));
    chk({nm, " onehot"}, 32'($countones(fl_v[idx][5:3])), 32'd1);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    logic [5:0]  fl;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 32'h80,       32'h7F,   1,  F_GT};
    tbl[1]  = '{0, 32'h5A,       32'h5A,   8,  F_EQ};
    tbl[2]  = '{1, 32'hFF,       32'hFE,   3,  F_GT};
    tbl[3]  = '{1, 32'h40,       32'h80,   1,  F_LT};
    tbl[4]  = '{3, 32'h1,        32'h0,    1,  F_GT};
    tbl[5]  = '{3, 32'h0,        32'h0,    1,  F_EQ};
    tbl[6]  = '{5, 32'h7F,       32'h7F,   2,  F_EQ};
    tbl[7]  = '{5, 32'h05,       32'h06,   2,  F_LT};
    tbl[8]  = '{5, 32'h40,       32'h3F,   1,  F_GT};
    tbl[9]  = '{8, 32'h10,       32'h11,   8,  F_LT};
    tbl[10] = '{9, 32'hFFFFFFFF, 32'h0,    1,  F_GT};
    tbl[11] = '{2, 32'h8000,     32'h8001, 16, F_LT};

    in_valid_drv = 1'b0; out_ready_drv = 1'b1; sel = 0; a_drv = '0; b_drv = '0;
    rst_n = 1'b0;
    #23;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("rst_ir_%0d", g), 32'(ir_v[g]), 32'd1);
      chk($sformatf("rst_ov_%0d", g), 32'(ov_v[g]), 32'd0);
      chk($sformatf("rst_busy_%0d", g), 32'(busy_v[g]), 32'd0);
      chk($sformatf("rst_fl_%0d", g), 32'(fl_v[g]), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_cmp(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].k, tbl[i].fl, $sformatf("vec%0d", i));

    // Backpressure: result held while out_ready is low.
    out_ready_drv = 1'b0;
    run_cmp(0, 32'h80, 32'h7F, 1, F_GT, "bp");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_ov", 32'(ov_v[0]), 32'd1);
      chk("bp_hold_ir", 32'(ir_v[0]), 32'd0);
      chk("bp_hold_fl", 32'(fl_v[0]), 32'(F_GT));
    end
    out_ready_drv = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_ov", 32'(ov_v[0]), 32'd0);
    chk("bp_rel_ir", 32'(ir_v[0]), 32'd1);
    chk("bp_persist_fl", 32'(fl_v[0]), 32'(F_GT));

    // Asynchronous reset in the middle of a 16-cycle equal compare.
    sel = 2; a_drv = 32'h1234; b_drv = 32'h1234; in_valid_drv = 1'b1;
    @(posedge clk); #1;
    in_valid_drv = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_busy", 32'(busy_v[2]), 32'd1);
    chk("mid_ov", 32'(ov_v[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_ir", 32'(ir_v[2]), 32'd1);
    chk("arst_ov", 32'(ov_v[2]), 32'd0);
    chk("arst_busy", 32'(busy_v[2]), 32'd0);
    chk("arst_fl", 32'(fl_v[2]), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmp(2, 32'h0001, 32'h0000, 16, F_GT, "post_rst");

    // Random regression on the WIDTH {1,7,32} x DIGIT {1,4,WIDTH} instances.
    for (int idx = 3; idx < NDUT; idx++) begin
      for (int n = 0; n < 12; n++) begin
        logic [31:0] ra, rb;
        int w, d;
        w  = cfg_w(idx);
        d  = cfg_d(idx);
        ra = $urandom & wmask(w);
        case ($urandom_range(0, 2))
          0:       rb = $urandom & wmask(w);
          1:       rb = ra;
          default: rb = ra ^ (32'd1 << $urandom_range(0, w - 1));
        endcase
        run_cmp(idx, ra, rb, ref_k(w, d, ra, rb), ref_flags(w, ra, rb),
                $sformatf("rnd%0d_%0d", idx, n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
